f33m_mult_arbiter: RTL and testbench
====================================

# f33m_mult_arbiter

Round-robin arbiter and sequencer that shares one `f33m_mult` instance (GF(3^{3M}) multiplier) among four requesters. It latches the winning requester's operands, holds the multiplier in reset while idle, releases it to compute, and captures the product. It then returns the product with a one-cycle acknowledge. A watchdog flags a multiplier that never raises `done`. It sits between the pairing-level control FSMs and a single external `f33m_mult` datapath instance.

## Interface
- `TMO`, 16'd2000, max cycles in WAIT before a timeout abort (1..65535)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (low = reset)
- `req`  in  4  per-requester level request
- `a_bus`  in  4*(`W3+1)  operand a; requester i at bits [(i+1)*(`W3+1)-1 : i*(`W3+1)]
- `b_bus`  in  4*(`W3+1)  operand b, same packing
- `gnt`  out  4  one-hot grant, held from START through DONE
- `ack`  out  4  one-hot, one-cycle pulse in DONE
- `c`  out  `W3+1  last captured product, held until next capture
- `busy`  out  1  high in any state but IDLE
- `err`  out  1  sticky timeout flag, cleared only by reset
- `mult_reset`  out  1  to `f33m_mult.reset`
- `mult_a`, `mult_b`  out  `W3+1 each  to `f33m_mult.a`, `.b`
- `mult_c`  in  `W3+1  from `f33m_mult.c`
- `mult_done`  in  1  from `f33m_mult.done`

## Operation
- All outputs are registered. Reset values: `gnt`=0, `ack`=0, `c`=0, `busy`=0, `err`=0, `mult_reset`=1, `mult_a`=`mult_b`=0. Internal state: state=IDLE, `ptr`=3, `cnt`=0.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE
  - If `req`≠0, select the first set bit in the order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  - Register the winner's operands into `mult_a`/`mult_b`, set `gnt`, set `ptr`←winner, go to START.
  - `req` is sampled only in IDLE. Requests in other states are ignored.
- START: `mult_reset` stays 1, `cnt`←0, go to WAIT.
- WAIT
  - `mult_reset`=0 and `cnt` increments each cycle.
  - On `mult_done`=1: `c`←`mult_c`, go to DONE.
  - Otherwise, if `cnt`==TMO-1: `err`←1, `c` is left unchanged, go to DONE.
  - `mult_done` is ignored in every state except WAIT. The multiplier's `done` is already cleared because `mult_reset` was high for at least one cycle.
- DONE: `ack[winner]`=1 for exactly this cycle, `mult_reset`←1, then go to IDLE with `gnt`←0.
- `mult_reset` is high in every state except WAIT.
- Operands are latched at grant. Requester bus changes after grant have no effect.
- A requester that drops `req` mid-operation still receives its `ack` and product.
- A requester must drop `req` no later than the cycle after its `ack`; a `req` still high in IDLE is a new operation.
- Asserting reset mid-operation aborts immediately to the reset values. No `ack` is issued and the multiplier is held in reset.

## Timing
- Request first seen high in IDLE at cycle t: `gnt` and operands valid at t+1 (START), WAIT from t+2.
- `mult_done` high at cycle t+2+L: `c` and `ack` valid at t+3+L (DONE), IDLE at t+4+L, next grant earliest at t+5+L.
- Back-to-back throughput: one product per L+4 cycles.
- Timeout: `err` and `ack` at t+2+TMO.

## Test plan
- Reset behaviour: hold reset low 3 cycles while `req`=4'b1111. Required: all outputs at reset values, `mult_reset`=1; on release, first grant goes to 4'b0001.
- Single request: `req`=4'b0100 with a2=3, b2=5 (small field elements). Required:
  - `gnt`=4'b0100 one cycle after the request;
  - `ack`=4'b0100 one cycle after `mult_done`;
  - `c` equals the golden product;
  - `busy` falls the cycle after `ack`.
- Fairness: all four requesters hold `req` and drop it on `ack`. Required: grant order 0,1,2,3,0; each `ack` pulse is exactly one cycle.
- Operand isolation: change requester 2's `a_bus` slice and toggle `req[1]` during WAIT. Required: product uses the latched operands; no grant change until DONE has passed.
- Timeout: bench model never raises `mult_done`, TMO=16. Required: `ack` at cycle t+18, `err`=1 and stays high, `c` unchanged; the next request still completes normally.
- Mid-op reset: assert reset during WAIT. Required: no `ack`, `gnt`=0, `mult_reset`=1 immediately (asynchronous), `ptr` restarts at requester 0.

Source files
------------

// File: rtl/f33m_mult_arbiter.sv
`default_nettype none
`ifndef W3
`define W3 17
`endif
// ============================================================================
// Module   : f33m_mult_arbiter
// Purpose  : Round-robin sharing of one f33m_mult among four requesters,
//            with operand latching, product capture and a done watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module f33m_mult_arbiter #(
  parameter int TMO = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*(`W3+1)-1:0] a_bus,
  input  logic [4*(`W3+1)-1:0] b_bus,
  output logic [3:0]           gnt,
  output logic [3:0]           ack,
  output logic [`W3:0]         c,
  output logic                 busy,
  output logic                 err,
  output logic                 mult_reset,
  output logic [`W3:0]         mult_a,
  output logic [`W3:0]         mult_b,
  input  logic [`W3:0]         mult_c,
  input  logic                 mult_done
);

  localparam int          C_W        = `W3 + 1;
  localparam logic [15:0] C_CNT_LAST = 16'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_ptr;
  logic [1:0]     w_ptr_nxt;
  logic [15:0]    r_cnt;
  logic [15:0]    w_cnt_nxt;
  logic [3:0]     r_gnt;
  logic [3:0]     w_gnt_nxt;
  logic [3:0]     r_ack;
  logic [3:0]     w_ack_nxt;
  logic [C_W-1:0] r_c;
  logic [C_W-1:0] w_c_nxt;
  logic           r_busy;
  logic           w_busy_nxt;
  logic           r_err;
  logic           w_err_nxt;
  logic           r_mult_reset;
  logic           w_mult_reset_nxt;
  logic [C_W-1:0] r_mult_a;
  logic [C_W-1:0] w_mult_a_nxt;
  logic [C_W-1:0] r_mult_b;
  logic [C_W-1:0] w_mult_b_nxt;

  logic           w_found;
  logic [1:0]     w_win;
  logic [1:0]     w_idx;
  logic [C_W-1:0] w_a_win;
  logic [C_W-1:0] w_b_win;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_a_win = a_bus[int'(w_win)*C_W +: C_W];
  assign w_b_win = b_bus[int'(w_win)*C_W +: C_W];

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_gnt_nxt        = r_gnt;
    w_ack_nxt        = 4'b0000;
    w_c_nxt          = r_c;
    w_err_nxt        = r_err;
    w_mult_reset_nxt = 1'b1;
    w_mult_a_nxt     = r_mult_a;
    w_mult_b_nxt     = r_mult_b;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_START;
          w_gnt_nxt    = 4'b0001 << w_win;
          w_ptr_nxt    = w_win;
          w_mult_a_nxt = w_a_win;
          w_mult_b_nxt = w_b_win;
        end
      end
      S_START: begin
        w_cnt_nxt        = 16'd0;
        w_mult_reset_nxt = 1'b0;
        w_state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (mult_done) begin
          w_c_nxt     = mult_c;
          w_ack_nxt   = 4'b0001 << r_ptr;
          w_state_nxt = S_DONE;
        end else if (r_cnt == C_CNT_LAST) begin
          // Abort keeps the previous product so downstream sees stale but valid data.
          w_err_nxt   = 1'b1;
          w_ack_nxt   = 4'b0001 << r_ptr;
          w_state_nxt = S_DONE;
        end else begin
          w_mult_reset_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_gnt_nxt   = 4'b0000;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd3;
      r_cnt        <= 16'd0;
      r_gnt        <= 4'b0000;
      r_ack        <= 4'b0000;
      r_c          <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_mult_reset <= 1'b1;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_ack        <= w_ack_nxt;
      r_c          <= w_c_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
      r_mult_reset <= w_mult_reset_nxt;
      r_mult_a     <= w_mult_a_nxt;
      r_mult_b     <= w_mult_b_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign c          = r_c;
  assign busy       = r_busy;
  assign err        = r_err;
  assign mult_reset = r_mult_reset;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;

endmodule
`default_nettype wire

// File: tb/tb_f33m_mult_arbiter.sv
`default_nettype none
`ifndef W3
`define W3 17
`endif
// ============================================================================
// Module   : tb_f33m_mult_arbiter
// Purpose  : Directed self-checking bench with a behavioural multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f33m_mult_arbiter;

  localparam int W = `W3 + 1;

  typedef struct packed {
    logic [3:0]   id;
    logic [W-1:0] c;
  } sb_t;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     req   = 4'b0000;
  logic [4*W-1:0] a_bus = '0;
  logic [4*W-1:0] b_bus = '0;
  logic [3:0]     gnt;
  logic [3:0]     ack;
  logic [W-1:0]   c;
  logic           busy;
  logic           err;
  logic           mult_reset;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [W-1:0]   mult_c    = '0;
  logic           mult_done = 1'b0;

  int   m_cnt  = 0;
  int   m_lat  = 5;
  logic m_hang = 1'b0;

  int           tests  = 0;
  int           fails  = 0;
  sb_t          sb[$];
  logic [W-1:0] last_c = '0;

  always #5 clk = ~clk;

  f33m_mult_arbiter #(.TMO(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .gnt        (gnt),
    .ack        (ack),
    .c          (c),
    .busy       (busy),
    .err        (err),
    .mult_reset (mult_reset),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_c     (mult_c),
    .mult_done  (mult_done)
  );

  // Stand-in for the field multiplier: any fixed function of (a, b) will do.
  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
    return W'(a * 3 + b * 5 + 1);
  endfunction

  always @(posedge clk) begin
    if (mult_reset) begin
      m_cnt     <= 0;
      mult_done <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!m_hang && m_cnt == m_lat - 1) begin
        mult_done <= 1'b1;
        mult_c    <= golden(mult_a, mult_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    sb_t e;
    e.id   = 4'b0001 << i;
    e.c    = golden(a, b);
    last_c = e.c;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int budget);
    int  n;
    sb_t e;
    n = 0;
    while (ack == 4'b0000 && n < budget) begin
      step();
      n++;
    end
    check("ack_seen", (ack != 4'b0000), 1);
    if (ack != 4'b0000) begin
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ack_id", ack, e.id);
        check("gnt_hold", gnt, e.id);
        check("product", c, e.c);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset held with all requesters asserted
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, W'(10 + i), W'(20 + i));
    repeat (3) step();
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_c", c, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mult_reset", mult_reset, 1);
    check("rst_mult_a", mult_a, 0);
    check("rst_mult_b", mult_b, 0);

    // Fairness: 0,1,2,3 then requester 0 again
    for (int k = 0; k < 5; k++) push_op(k % 4, W'(10 + k % 4), W'(20 + k % 4));
    reset = 1'b1;
    step();
    check("first_gnt", gnt, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_ack(40);
      if (k != 0) req = req & ~ack;
      step();
      check("ack_pulse", ack, 0);
    end
    check("fair_idle_busy", busy, 0);

    // Single request from requester 2
    set_op(2, W'(3), W'(5));
    push_op(2, W'(3), W'(5));
    req = 4'b0100;
    step();
    check("single_gnt", gnt, 4'b0100);
    check("single_mult_a", mult_a, 3);
    check("single_mult_b", mult_b, 5);
    req = 4'b0000;
    n = 0;
    while (!mult_done && n < 20) begin
      step();
      n++;
    end
    check("done_seen", mult_done, 1);
    step();
    wait_ack(0);
    step();
    check("single_ack_pulse", ack, 0);
    check("single_busy_fall", busy, 0);

    // Operand isolation and ignored requests during WAIT
    set_op(2, W'(7), W'(9));
    push_op(2, W'(7), W'(9));
    req = 4'b0100;
    step();
    check("iso_gnt", gnt, 4'b0100);
    req = 4'b0000;
    set_op(2, W'(8'h55), W'(8'h66));
    step();
    req = 4'b0010;
    step();
    check("iso_gnt_wait1", gnt, 4'b0100);
    check("iso_mult_a", mult_a, 7);
    req = 4'b0000;
    step();
    check("iso_gnt_wait2", gnt, 4'b0100);
    wait_ack(30);
    step();
    check("iso_gnt_clear", gnt, 0);
    check("iso_ack_pulse", ack, 0);

    // Timeout: multiplier never signals done
    m_hang = 1'b1;
    begin
      sb_t e;
      e.id = 4'b0001;
      e.c  = last_c;
      sb.push_back(e);
    end
    set_op(0, W'(1), W'(1));
    req = 4'b0001;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 1) begin
        check("tmo_gnt", gnt, 4'b0001);
        req = 4'b0000;
      end
    end
    check("tmo_no_early_ack", ack, 0);
    check("tmo_no_early_err", err, 0);
    step();
    wait_ack(0);
    check("tmo_err", err, 1);
    step();
    check("tmo_err_sticky", err, 1);
    check("tmo_busy_fall", busy, 0);
    m_hang = 1'b0;

    // Normal completion after timeout
    set_op(3, W'(2), W'(4));
    push_op(3, W'(2), W'(4));
    req = 4'b1000;
    step();
    check("post_tmo_gnt", gnt, 4'b1000);
    req = 4'b0000;
    wait_ack(30);
    check("post_tmo_err", err, 1);
    step();

    // Reset asserted mid-operation
    set_op(1, W'(6), W'(6));
    req = 4'b0010;
    step();
    check("midrst_gnt", gnt, 4'b0010);
    req = 4'b0000;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check("midrst_gnt_async", gnt, 0);
    check("midrst_mult_reset", mult_reset, 1);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_c", c, 0);
    repeat (2) begin
      step();
      check("midrst_no_ack", ack, 0);
    end
    reset = 1'b1;
    set_op(0, W'(11), W'(13));
    set_op(3, W'(12), W'(14));
    push_op(0, W'(11), W'(13));
    req = 4'b1001;
    step();
    check("midrst_ptr_restart", gnt, 4'b0001);
    req = 4'b0000;
    wait_ack(30);
    step();
    check("final_ack_pulse", ack, 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
